mole_evaluator: RTL and testbench

- Consumer end of the button-decoder interface: takes the `eval_now` / `user_guess` pair and runs one whack-a-mole round per mole.
- Places moles pseudo-randomly in holes 0–4, times each mole, and judges every guess as hit or miss.
- Tracks score and lives, and drives the display and LED blocks through `mole_pos`, `score`, `lives` and `game_over`.

---
 rtl/mole_evaluator.sv | 199 +++++++++++++++++++
 tb/tb_mole_evaluator.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mole_evaluator.sv
// mole_evaluator: whack-a-mole round engine. Places a mole in holes 0-4 using
// an 8-bit LFSR, times it with a divided game tick, and judges each guess
// edge from the button decoder as a hit or a miss. It tracks score and lives.
//
// Decoder contract: eval_now is a level-style valid with no ready. One guess
// is taken per rising edge of eval_now, and user_guess is sampled only in that
// cycle. Holding eval_now high never produces a second guess. The guess is
// judged in the cycle of the edge, and its effects are visible one cycle later.
module mole_evaluator #(
   parameter int TICK_DIV   = 1000000,
   parameter int MOLE_TICKS = 100,
   parameter int COOL_TICKS = 25,
   parameter int LIVES      = 3,
   parameter int SCORE_W    = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               eval_now,
   input  logic [2:0]         user_guess,
   output logic [2:0]         mole_pos,
   output logic [SCORE_W-1:0] score,
   output logic [1:0]         lives,
   output logic               hit_pulse,
   output logic               miss_pulse,
   output logic               game_over
);

   localparam int TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int TMAX    = (MOLE_TICKS > COOL_TICKS) ? MOLE_TICKS : COOL_TICKS;
   localparam int TIMER_W = $clog2(TMAX + 1);
   localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICK_DIV - 1);
   localparam logic [TIMER_W-1:0] MOLE_INIT  = TIMER_W'(MOLE_TICKS);
   localparam logic [TIMER_W-1:0] COOL_INIT  = TIMER_W'(COOL_TICKS);
   localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);
   localparam logic [1:0]         LIVES_INIT = 2'(LIVES);
   localparam logic [2:0]         NO_MOLE    = 3'd5;
   localparam logic [7:0]         LFSR_SEED  = 8'hA5;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_SPAWN    = 3'd1,
      S_ACTIVE   = 3'd2,
      S_COOLDOWN = 3'd3,
      S_OVER     = 3'd4
   } state_t;

   state_t               state_q, state_d;
   logic [2:0]           mole_pos_q, mole_pos_d;
   logic [2:0]           prev_hole_q, prev_hole_d;
   logic [SCORE_W-1:0]   score_q, score_d;
   logic [1:0]           lives_q, lives_d;
   logic                 hit_q, hit_d;
   logic                 miss_q, miss_d;
   logic                 game_over_q, game_over_d;
   logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
   logic [TIMER_W-1:0]   timer_q, timer_d;
   logic [7:0]           lfsr_q, lfsr_d;
   logic                 start_q, start_d;
   logic                 eval_q, eval_d;

   logic                 tick;
   logic                 start_rise;
   logic                 eval_rise;
   logic [2:0]           guess;
   logic [2:0]           cand_mod;
   logic [2:0]           cand;
   logic                 timer_last;

   // Free-running helpers: tick divider, LFSR, input edge history, spawn candidate
   always_comb begin
      tick       = (tick_cnt_q == TICK_LAST);
      tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
      // Fibonacci taps 8,6,5,4 (bits 7,5,4,3); a nonzero seed never reaches zero
      lfsr_d     = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      start_d    = start;
      eval_d     = eval_now;
      start_rise = start & ~start_q;
      eval_rise  = eval_now & ~eval_q;
      guess      = (user_guess > 3'd4) ? NO_MOLE : user_guess;
      timer_last = (timer_q <= TIMER_ONE);
      cand_mod   = (lfsr_q[2:0] >= 3'd5) ? (lfsr_q[2:0] - 3'd5) : lfsr_q[2:0];
      // Never place a mole in the same hole twice in a row
      if (cand_mod == prev_hole_q) begin
         cand = (cand_mod == 3'd4) ? 3'd0 : (cand_mod + 3'd1);
      end else begin
         cand = cand_mod;
      end
   end

   // Round FSM: next state plus registered outputs; pulses default low every cycle
   always_comb begin
      state_d     = state_q;
      mole_pos_d  = mole_pos_q;
      prev_hole_d = prev_hole_q;
      score_d     = score_q;
      lives_d     = lives_q;
      hit_d       = 1'b0;
      miss_d      = 1'b0;
      game_over_d = game_over_q;
      timer_d     = timer_q;
      unique case (state_q)
         S_IDLE: begin
            mole_pos_d = NO_MOLE;
            if (start_rise) state_d = S_SPAWN;
         end
         S_SPAWN: begin
            mole_pos_d  = cand;
            prev_hole_d = cand;
            timer_d     = MOLE_INIT;
            state_d     = S_ACTIVE;
         end
         S_ACTIVE: begin
            if (eval_rise && (guess == mole_pos_q)) begin
               // A hit outranks a timeout landing in the same cycle
               hit_d      = 1'b1;
               score_d    = (score_q == '1) ? score_q : score_q + SCORE_W'(1);
               mole_pos_d = NO_MOLE;
               timer_d    = COOL_INIT;
               state_d    = S_COOLDOWN;
            end else if ((eval_rise && (guess != NO_MOLE)) || (tick && timer_last)) begin
               miss_d     = 1'b1;
               lives_d    = lives_q - 2'd1;
               mole_pos_d = NO_MOLE;
               if (lives_q == 2'd1) begin
                  game_over_d = 1'b1;
                  state_d     = S_OVER;
               end else begin
                  timer_d = COOL_INIT;
                  state_d = S_COOLDOWN;
               end
            end else if (tick) begin
               timer_d = timer_q - TIMER_ONE;
            end
         end
         S_COOLDOWN: begin
            mole_pos_d = NO_MOLE;
            if (tick) begin
               if (timer_last) state_d = S_SPAWN;
               else            timer_d = timer_q - TIMER_ONE;
            end
         end
         S_OVER: begin
            mole_pos_d = NO_MOLE;
            if (start_rise) begin
               score_d     = '0;
               lives_d     = LIVES_INIT;
               game_over_d = 1'b0;
               state_d     = S_SPAWN;
            end
         end
         default: begin
            mole_pos_d = NO_MOLE;
            state_d    = S_IDLE;
         end
      endcase
   end

   // State and datapath registers, async active-low reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         mole_pos_q  <= NO_MOLE;
         prev_hole_q <= NO_MOLE;
         score_q     <= '0;
         lives_q     <= LIVES_INIT;
         hit_q       <= 1'b0;
         miss_q      <= 1'b0;
         game_over_q <= 1'b0;
         tick_cnt_q  <= '0;
         timer_q     <= '0;
         lfsr_q      <= LFSR_SEED;
         start_q     <= 1'b0;
         eval_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         mole_pos_q  <= mole_pos_d;
         prev_hole_q <= prev_hole_d;
         score_q     <= score_d;
         lives_q     <= lives_d;
         hit_q       <= hit_d;
         miss_q      <= miss_d;
         game_over_q <= game_over_d;
         tick_cnt_q  <= tick_cnt_d;
         timer_q     <= timer_d;
         lfsr_q      <= lfsr_d;
         start_q     <= start_d;
         eval_q      <= eval_d;
      end
   end

   assign mole_pos   = mole_pos_q;
   assign score      = score_q;
   assign lives      = lives_q;
   assign hit_pulse  = hit_q;
   assign miss_pulse = miss_q;
   assign game_over  = game_over_q;

endmodule

// File: tb/tb_mole_evaluator.sv
// Directed bench for mole_evaluator with a short tick so that a full game fits
// in a few hundred cycles. The score is 2 bits wide so that saturation is reachable.
module tb_mole_evaluator;

   localparam int TICK_DIV   = 4;
   localparam int MOLE_TICKS = 3;
   localparam int COOL_TICKS = 2;
   localparam int LIVES      = 3;
   localparam int SCORE_W    = 2;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               start = 1'b0;
   logic               eval_now = 1'b0;
   logic [2:0]         user_guess = 3'd5;
   logic [2:0]         mole_pos;
   logic [SCORE_W-1:0] score;
   logic [1:0]         lives;
   logic               hit_pulse;
   logic               miss_pulse;
   logic               game_over;

   int err_cnt = 0;
   int chk_cnt = 0;
   int hit_seen = 0;
   int miss_seen = 0;

   // Clock and reset
   always #5 clk = ~clk;

   mole_evaluator #(
      .TICK_DIV(TICK_DIV), .MOLE_TICKS(MOLE_TICKS), .COOL_TICKS(COOL_TICKS),
      .LIVES(LIVES), .SCORE_W(SCORE_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .eval_now(eval_now),
      .user_guess(user_guess), .mole_pos(mole_pos), .score(score),
      .lives(lives), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse),
      .game_over(game_over)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // One clock: outputs sampled on the falling edge, pulses tallied once each
   task automatic step();
      @(posedge clk);
      @(negedge clk);
      if (hit_pulse)  hit_seen++;
      if (miss_pulse) miss_seen++;
   endtask

   task automatic wait_mole(output int n, output bit ok);
      n  = 0;
      ok = 1'b0;
      while (n < 40) begin
         if (mole_pos != 3'd5) begin
            ok = 1'b1;
            break;
         end
         step();
         n++;
      end
   endtask

   task automatic wait_miss(output int n, output bit ok);
      n  = 0;
      ok = 1'b0;
      while (n < 40 && !ok) begin
         step();
         n++;
         if (miss_pulse) ok = 1'b1;
      end
   endtask

   task automatic do_hit(input string tag, input int exp_score);
      int n;
      bit ok;
      wait_mole(n, ok);
      check_eq({tag, "_mole_up"}, ok, 1);
      eval_now = 1'b0;
      step();
      user_guess = mole_pos;
      eval_now   = 1'b1;
      step();
      check_eq({tag, "_hit"}, hit_pulse, 1);
      check_eq({tag, "_score"}, score, exp_score);
      eval_now = 1'b0;
   endtask

   initial begin
      int n, h0, m0, mole_a, mole_b;
      bit ok;

      // Reset values while rst_n is held low
      repeat (3) @(negedge clk);
      check_eq("rst_mole", mole_pos, 5);
      check_eq("rst_score", score, 0);
      check_eq("rst_lives", lives, 3);
      check_eq("rst_hit", hit_pulse, 0);
      check_eq("rst_miss", miss_pulse, 0);
      check_eq("rst_over", game_over, 0);

      // Release, start on the second edge: LFSR A5 -> 4A -> 95, 95[2:0]=5 -> hole 0
      rst_n = 1'b1;
      step();
      start = 1'b1;
      step();
      step();
      check_eq("first_mole", mole_pos, 0);
      check_eq("start_score", score, 0);
      check_eq("start_lives", lives, 3);
      check_eq("start_over", game_over, 0);
      start = 1'b0;

      // Hit on the very edge of the final timeout tick (edge 12 after release)
      repeat (8) step();
      user_guess = 3'd0;
      eval_now   = 1'b1;
      step();
      check_eq("late_hit", hit_pulse, 1);
      check_eq("late_hit_miss", miss_pulse, 0);
      check_eq("late_hit_score", score, 1);
      check_eq("late_hit_lives", lives, 3);
      check_eq("late_hit_mole", mole_pos, 5);

      // eval_now stays high through the cooldown: no further judgement
      h0 = hit_seen;
      m0 = miss_seen;
      wait_mole(n, ok);
      check_eq("cool_spawn", ok, 1);
      check_eq("cool_len", (n >= 6 && n <= 9), 1);
      check_eq("held_no_hit", hit_seen - h0, 0);
      check_eq("held_no_miss", miss_seen - m0, 0);
      check_eq("new_mole_range", mole_pos < 3'd5, 1);
      check_eq("new_mole_differs", mole_pos != 3'd0, 1);
      mole_a = int'(mole_pos);

      // Wrong guess
      eval_now = 1'b0;
      step();
      user_guess = 3'((mole_a + 1) % 5);
      eval_now   = 1'b1;
      step();
      check_eq("wrong_miss", miss_pulse, 1);
      check_eq("wrong_hit", hit_pulse, 0);
      check_eq("wrong_lives", lives, 2);
      check_eq("wrong_score", score, 1);
      check_eq("wrong_mole", mole_pos, 5);

      // A guess during cooldown is ignored
      eval_now = 1'b0;
      step();
      user_guess = 3'(mole_a);
      eval_now   = 1'b1;
      step();
      check_eq("cool_ign_miss", miss_pulse, 0);
      check_eq("cool_ign_hit", hit_pulse, 0);
      check_eq("cool_ign_lives", lives, 2);
      eval_now = 1'b0;

      // Guesses 5 and 7 in ACTIVE are ignored
      wait_mole(n, ok);
      check_eq("spawn2", ok, 1);
      mole_b = int'(mole_pos);
      check_eq("mole_b_differs", mole_b != mole_a, 1);
      user_guess = 3'd5;
      eval_now   = 1'b1;
      step();
      check_eq("none5_miss", miss_pulse, 0);
      check_eq("none5_hit", hit_pulse, 0);
      check_eq("none5_mole", mole_pos, mole_b);
      eval_now = 1'b0;
      step();
      user_guess = 3'd7;
      eval_now   = 1'b1;
      step();
      check_eq("none7_miss", miss_pulse, 0);
      check_eq("none7_mole", mole_pos, mole_b);
      check_eq("none7_lives", lives, 2);
      eval_now = 1'b0;

      // Two timeouts: lives 2 -> 1 -> 0 and game over
      wait_miss(n, ok);
      check_eq("timeout1", ok, 1);
      check_eq("timeout1_lives", lives, 1);
      check_eq("timeout1_over", game_over, 0);
      wait_mole(n, ok);
      check_eq("spawn3", ok, 1);
      wait_miss(n, ok);
      check_eq("timeout2", ok, 1);
      check_eq("timeout_len", (n >= 9 && n <= 12), 1);
      check_eq("over_flag", game_over, 1);
      check_eq("over_lives", lives, 0);
      check_eq("over_mole", mole_pos, 5);
      check_eq("over_score", score, 1);
      repeat (12) step();
      check_eq("over_hold_flag", game_over, 1);
      check_eq("over_hold_mole", mole_pos, 5);
      check_eq("over_hold_lives", lives, 0);

      // Restart from OVER; start stays high through several rounds
      start = 1'b1;
      step();
      check_eq("restart_score", score, 0);
      check_eq("restart_lives", lives, 3);
      check_eq("restart_over", game_over, 0);
      step();
      check_eq("restart_mole", mole_pos < 3'd5, 1);
      do_hit("sat1", 1);
      do_hit("sat2", 2);
      do_hit("sat3", 3);
      do_hit("sat4", 3);
      check_eq("sat_lives", lives, 3);

      // start edge while ACTIVE is ignored
      start = 1'b0;
      wait_mole(n, ok);
      check_eq("spawn_ign", ok, 1);
      mole_a = int'(mole_pos);
      start = 1'b1;
      step();
      check_eq("start_ign_mole", mole_pos, mole_a);
      check_eq("start_ign_score", score, 3);

      // Asynchronous reset mid-ACTIVE with eval_now high
      user_guess = 3'd5;
      eval_now   = 1'b1;
      step();
      #2 rst_n = 1'b0;
      start = 1'b0;
      #1;
      check_eq("arst_mole", mole_pos, 5);
      check_eq("arst_score", score, 0);
      check_eq("arst_lives", lives, 3);
      check_eq("arst_hit", hit_pulse, 0);
      check_eq("arst_miss", miss_pulse, 0);
      @(negedge clk);
      rst_n = 1'b1;
      h0 = hit_seen;
      m0 = miss_seen;
      step();
      start = 1'b1;
      step();
      step();
      check_eq("arst_first_mole", mole_pos, 0);
      user_guess = 3'd0;
      repeat (3) step();
      check_eq("arst_held_hit", hit_seen - h0, 0);
      check_eq("arst_held_miss", miss_seen - m0, 0);
      eval_now = 1'b0;
      step();
      eval_now = 1'b1;
      step();
      check_eq("arst_rehit", hit_pulse, 1);
      check_eq("arst_rehit_score", score, 1);
      eval_now = 1'b0;
      start    = 1'b0;
      step();

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
